// File: rtl/reg_write_arbiter_if.sv
// Requester/register-side bundle for the shared-register write arbiter.
// master = requesters and the register they feed, slave = the arbiter.
interface reg_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic                 en;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   din;
  logic [NREQ-1:0]      ack;
  logic                 reg_wen;
  logic [DW-1:0]        reg_in;
  logic [1:0]           gnt_id;
  logic [1:0]           last_owner;
  logic [7:0]           wr_count;

  modport master (
    output en, req, din,
    input  ack, reg_wen, reg_in, gnt_id, last_owner, wr_count
  );

  modport slave (
    input  en, req, din,
    output ack, reg_wen, reg_in, gnt_id, last_owner, wr_count
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of four requesters a single-cycle write
// into a shared 8-bit register; tracks last writer and a wrapping write count.
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  reg_write_arbiter_if.slave bus
);

  localparam int IDW = 2;

  logic [IDW-1:0]  ptr_p1;
  logic [NREQ-1:0] ack_p1;
  logic            vld_p1;
  logic [DW-1:0]   data_p1;
  logic [IDW-1:0]  id_p1;
  logic [IDW-1:0]  last_p1;
  logic [7:0]      cnt_p1;

  logic [NREQ-1:0] elig_p0;
  logic            hit_p0;
  logic [IDW-1:0]  win_p0;
  logic [DW-1:0]   sel_p0;
  logic            grant_p0;

  // Lowest rotation offset from ptr wins; MSB of the result flags any hit.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] elig,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0]   r;
    logic [IDW-1:0] idx;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDW'(k);
      if (elig[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // Stage p0: arbitration on live requests, masking whoever holds ack now
  always_comb begin
    elig_p0          = bus.req & ~ack_p1;
    {hit_p0, win_p0} = rr_pick(elig_p0, ptr_p1);
    grant_p0         = bus.en && hit_p0;
    sel_p0           = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_p0 == IDW'(i)) sel_p0 = bus.din[i*DW +: DW];
    end
  end

  // Stage p1: registered grant, register write port and bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p1  <= '0;
      ack_p1  <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      last_p1 <= '0;
      cnt_p1  <= '0;
    end else if (grant_p0) begin
      ack_p1         <= '0;
      ack_p1[win_p0] <= 1'b1;
      vld_p1         <= 1'b1;
      data_p1        <= sel_p0;
      id_p1          <= win_p0;
      last_p1        <= win_p0;
      cnt_p1         <= cnt_p1 + 8'd1;
      ptr_p1         <= win_p0 + IDW'(1);
    end else begin
      ack_p1 <= '0;
      vld_p1 <= 1'b0;
    end
  end

  assign bus.ack        = ack_p1;
  assign bus.reg_wen    = vld_p1;
  assign bus.reg_in     = data_p1;
  assign bus.gnt_id     = id_p1;
  assign bus.last_owner = last_p1;
  assign bus.wr_count   = cnt_p1;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: stimulus queues expected grants,
// a negedge monitor pops and compares every grant the DUT presents.
module tb_reg_write_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  reg_write_arbiter #(.NREQ(4), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] data;
    logic [1:0] id;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data, input logic [7:0] cnt);
    exp_t e;
    e.ack  = 4'b0001 << id;
    e.data = data;
    e.id   = id;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    rst     = 1'b1;
    tick();
    chk("reset_wr_count", 32'(bus.wr_count), 32'h0);
    rst = 1'b0;
  endtask

  // Monitor: every presented grant must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.ack !== 4'b0000 || bus.reg_wen !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: ack=%b reg_wen=%b gnt_id=%0d, expected no grant",
                 bus.ack, bus.reg_wen, bus.gnt_id);
      end else begin
        mon_e = sb.pop_front();
        chk("ack",        32'(bus.ack),        32'(mon_e.ack));
        chk("reg_wen",    32'(bus.reg_wen),    32'h1);
        chk("reg_in",     32'(bus.reg_in),     32'(mon_e.data));
        chk("gnt_id",     32'(bus.gnt_id),     32'(mon_e.id));
        chk("last_owner", 32'(bus.last_owner), 32'(mon_e.id));
        chk("wr_count",   32'(bus.wr_count),   32'(mon_e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    bus.din = {8'h40, 8'h30, 8'h20, 8'h10};

    // Reset held two cycles with all requesting: everything stays zero
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ack",        32'(bus.ack),        32'h0);
      chk("rst_reg_wen",    32'(bus.reg_wen),    32'h0);
      chk("rst_reg_in",     32'(bus.reg_in),     32'h0);
      chk("rst_gnt_id",     32'(bus.gnt_id),     32'h0);
      chk("rst_last_owner", 32'(bus.last_owner), 32'h0);
      chk("rst_wr_count",   32'(bus.wr_count),   32'h0);
    end
    push(2'd0, 8'h10, 8'd1);
    rst = 1'b0;
    tick();
    bus.req = 4'b0000;
    tick();
    chk("post_rst_idle_ack", 32'(bus.ack), 32'h0);
    chk("sb_empty_reset", 32'(sb.size()), 32'h0);

    // Single requester 2
    do_reset();
    bus.din[23:16] = 8'h2A;
    bus.req = 4'b0100;
    push(2'd2, 8'h2A, 8'd1);
    tick();
    bus.req = 4'b0000;
    tick();
    chk("single_wr_count",   32'(bus.wr_count),   32'h1);
    chk("single_last_owner", 32'(bus.last_owner), 32'h2);
    chk("single_wen_low",    32'(bus.reg_wen),    32'h0);
    chk("single_reg_in_hold", 32'(bus.reg_in),    32'h2A);
    chk("single_gnt_id_hold", 32'(bus.gnt_id),    32'h2);
    chk("sb_empty_single", 32'(sb.size()), 32'h0);

    // Full contention: 0,1,2,3,0,1,2,3 back to back
    do_reset();
    bus.din = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.req = 4'b1111;
    push(2'd0, 8'h10, 8'd1); push(2'd1, 8'h20, 8'd2);
    push(2'd2, 8'h30, 8'd3); push(2'd3, 8'h40, 8'd4);
    push(2'd0, 8'h10, 8'd5); push(2'd1, 8'h20, 8'd6);
    push(2'd2, 8'h30, 8'd7); push(2'd3, 8'h40, 8'd8);
    repeat (8) tick();
    bus.req = 4'b0000;
    tick();
    chk("full_wr_count", 32'(bus.wr_count), 32'h8);
    chk("sb_empty_full", 32'(sb.size()), 32'h0);

    // Masking: requester 1 alone for 6 cycles gets 3 alternate-cycle writes
    do_reset();
    bus.req = 4'b0010;
    push(2'd1, 8'h20, 8'd1); push(2'd1, 8'h20, 8'd2); push(2'd1, 8'h20, 8'd3);
    repeat (6) tick();
    bus.req = 4'b0000;
    tick();
    chk("mask_wr_count", 32'(bus.wr_count), 32'h3);
    chk("sb_empty_mask", 32'(sb.size()), 32'h0);

    // Enable gating: ptr left at 1 by a grant to 0, so resume order is 1 then 0
    do_reset();
    bus.req = 4'b0001;
    push(2'd0, 8'h10, 8'd1);
    tick();
    bus.en  = 1'b0;
    bus.req = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("en0_no_ack", 32'(bus.ack), 32'h0);
    end
    push(2'd1, 8'h20, 8'd2);
    push(2'd0, 8'h10, 8'd3);
    bus.en = 1'b1;
    repeat (2) tick();
    bus.req = 4'b0000;
    tick();
    chk("en_wr_count", 32'(bus.wr_count), 32'h3);
    chk("sb_empty_en", 32'(sb.size()), 32'h0);

    // Reset mid-stream: pending grant discarded, restart at id 0
    do_reset();
    bus.req = 4'b1111;
    push(2'd0, 8'h10, 8'd1); push(2'd1, 8'h20, 8'd2); push(2'd2, 8'h30, 8'd3);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ack",        32'(bus.ack),        32'h0);
    chk("midrst_reg_wen",    32'(bus.reg_wen),    32'h0);
    chk("midrst_wr_count",   32'(bus.wr_count),   32'h0);
    chk("midrst_last_owner", 32'(bus.last_owner), 32'h0);
    chk("midrst_reg_in",     32'(bus.reg_in),     32'h0);
    push(2'd0, 8'h10, 8'd1);
    tick();
    bus.req = 4'b0000;
    tick();
    chk("midrst_restart_count", 32'(bus.wr_count), 32'h1);
    chk("sb_empty_midrst", 32'(sb.size()), 32'h0);

    // 256 grants: wr_count wraps back to 0
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 256; i++)
      push(2'(i % 4), 8'(16 * (i % 4 + 1)), 8'(i + 1));
    repeat (256) tick();
    bus.req = 4'b0000;
    tick();
    chk("wrap_wr_count",   32'(bus.wr_count),   32'h0);
    chk("wrap_last_owner", 32'(bus.last_owner), 32'h3);
    chk("sb_empty_wrap", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
